fetch_prefetch_queue: RTL

//  Parametrised next-generation fetch stage. Decouples I-cache access from decode

---
 rtl/fetch_prefetch_queue.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: one-outstanding I-cache requester feeding a DEPTH-entry {PC,IR,IAM,IAF} queue and the DE latch.
// Redirects flush queue and DE, mark any in-flight response stale; DE_STALL holds DE and backs the queue up into fetch.
module fetch_prefetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  output logic                     IC_REQ_V,
  output logic [XLEN-1:0]          IC_REQ_PC,
  input  logic                     IC_REQ_RDY,
  input  logic                     IC_RESP_V,
  input  logic [ILEN-1:0]          IC_RESP_IR,
  input  logic                     IC_RESP_FAULT,
  input  logic                     TRAP_V,
  input  logic [XLEN-1:0]          TRAP_VEC,
  input  logic                     BR_V,
  input  logic [XLEN-1:0]          BR_PC,
  input  logic                     DE_STALL,
  output logic                     DE_V,
  output logic [ILEN-1:0]          DE_IR,
  output logic [XLEN-1:0]          DE_PC,
  output logic [XLEN-1:0]          DE_NPC,
  output logic                     DE_IAM,
  output logic                     DE_IAF,
  output logic [$clog2(DEPTH):0]   Q_COUNT
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HALT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_fe_pc;
  logic            r_out;
  logic            r_stale;

  logic [XLEN-1:0] r_q_pc  [DEPTH];
  logic [ILEN-1:0] r_q_ir  [DEPTH];
  logic            r_q_iam [DEPTH];
  logic            r_q_iaf [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;

  logic            r_de_v;
  logic [ILEN-1:0] r_de_ir;
  logic [XLEN-1:0] r_de_pc;
  logic [XLEN-1:0] r_de_npc;
  logic            r_de_iam;
  logic            r_de_iaf;

  logic            w_flush;
  logic [XLEN-1:0] w_target;
  logic            w_aligned;
  logic            w_space;
  logic            w_req_v;
  logic            w_issue;
  logic            w_resp_ok;
  logic            w_mis_enq;
  logic            w_enq;
  logic            w_deq;
  logic            w_inflight;
  logic [ILEN-1:0] w_enq_ir;

  assign w_flush   = TRAP_V | BR_V;
  assign w_target  = TRAP_V ? TRAP_VEC : BR_PC;
  assign w_aligned = (r_fe_pc[1:0] == 2'b00);
  assign w_space   = (r_count + (AW+1)'(r_out)) < (AW+1)'(DEPTH);

  // Issue is suppressed during reset and in the flush cycle so no request ever targets a dead path.
  assign w_req_v   = RESET_N & ~w_flush & (r_state == S_FETCH) & w_aligned
                   & ~r_out & ~r_stale & w_space;
  assign w_issue   = w_req_v & IC_REQ_RDY;
  assign w_resp_ok = IC_RESP_V & ~r_stale & r_out & (r_state == S_WAIT) & ~w_flush;
  assign w_mis_enq = ~w_flush & (r_state == S_FETCH) & ~w_aligned & w_space;
  assign w_enq     = w_resp_ok | w_mis_enq;
  assign w_enq_ir  = w_mis_enq ? ILEN'(32'h0000_0013) : IC_RESP_IR;
  assign w_deq     = ~w_flush & ~DE_STALL & (r_count != '0);
  // A response returning in the flush cycle retires the in-flight request, so nothing is left stale.
  assign w_inflight = (r_out | r_stale) & ~IC_RESP_V;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_FETCH;
      r_fe_pc <= RESET_PC;
      r_out   <= 1'b0;
      r_stale <= 1'b0;
    end else if (w_flush) begin
      r_state <= S_FETCH;
      r_fe_pc <= w_target;
      r_out   <= 1'b0;
      r_stale <= w_inflight;
    end else begin
      if (IC_RESP_V && r_stale) r_stale <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_issue) begin
            r_out   <= 1'b1;
            r_state <= S_WAIT;
          end else if (w_mis_enq) begin
            r_state <= S_HALT;
          end
        end
        S_WAIT: begin
          if (w_resp_ok) begin
            r_out <= 1'b0;
            if (IC_RESP_FAULT) begin
              r_state <= S_HALT;
            end else begin
              r_fe_pc <= r_fe_pc + XLEN'(4);
              r_state <= S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_q_pc[r_wptr]  <= r_fe_pc;
      r_q_ir[r_wptr]  <= w_enq_ir;
      r_q_iam[r_wptr] <= w_mis_enq;
      r_q_iaf[r_wptr] <= w_resp_ok & IC_RESP_FAULT;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_de_v   <= 1'b0;
      r_de_ir  <= '0;
      r_de_pc  <= '0;
      r_de_npc <= '0;
      r_de_iam <= 1'b0;
      r_de_iaf <= 1'b0;
    end else if (w_flush) begin
      r_de_v <= 1'b0;
    end else if (!DE_STALL) begin
      if (w_deq) begin
        r_de_v   <= 1'b1;
        r_de_ir  <= r_q_ir[r_rptr];
        r_de_pc  <= r_q_pc[r_rptr];
        r_de_npc <= r_q_pc[r_rptr] + XLEN'(4);
        r_de_iam <= r_q_iam[r_rptr];
        r_de_iaf <= r_q_iaf[r_rptr];
      end else begin
        r_de_v <= 1'b0;
      end
    end
  end

  assign IC_REQ_V  = w_req_v;
  assign IC_REQ_PC = r_fe_pc;
  assign DE_V      = r_de_v;
  assign DE_IR     = r_de_ir;
  assign DE_PC     = r_de_pc;
  assign DE_NPC    = r_de_npc;
  assign DE_IAM    = r_de_iam;
  assign DE_IAF    = r_de_iaf;
  assign Q_COUNT   = r_count;

endmodule
